// File: rtl/spike_event_fifo.sv
// -----------------------------------------------------------------------------
// spike_event_fifo
//
// Captures rising edges of an upstream spike line as time-stamped events and
// queues them in a small FIFO for a downstream consumer.
//
// Each stored word is {timestamp, state}. The timestamp field is the value of
// the free-running counter in the capture cycle, before it increments. The
// state field is the 8-bit membrane state sampled in the same cycle.
//
// If an event arrives while the FIFO is full and nothing is being popped, the
// event is dropped. A drop sets a sticky overflow flag and increments a
// saturating drop counter.
//
// Ports
//   clk        sole clock; all state updates on the rising edge
//   rst_n      synchronous reset, active HIGH (1 = reset)
//   en         enables timestamp counting and event capture
//   spike      spike level from the upstream neuron
//   state      membrane state, sampled together with the event
//   clr        clears overflow and drop_cnt; does not touch FIFO or timestamp
//   out_ready  consumer accepts the head entry
//   out_valid  FIFO non-empty; out_data holds the oldest entry
//   out_data   head entry {timestamp, state}, timestamp in the MSBs
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: at least one event dropped since reset/clr
//   drop_cnt   dropped events, saturating at 255
//   timestamp  free-running time counter
// -----------------------------------------------------------------------------
module spike_event_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      spike,
    input  logic [7:0]                state,
    input  logic                      clr,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [TS_W+7:0]           out_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [7:0]                drop_cnt,
    output logic [TS_W-1:0]           timestamp
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = TS_W + 8;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [TS_W-1:0] ts_reg;
    logic            spike_d_reg;
    logic            overflow_reg;
    logic [7:0]      drop_cnt_reg;

    logic event_hit;
    logic push_req;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    // A spike held high produces one event: only the low-to-high transition counts.
    assign event_hit = spike & ~spike_d_reg;
    assign push_req  = event_hit & en;
    assign pop       = (count_reg != '0) & out_ready;
    assign full      = (count_reg == CW'(DEPTH));
    // When full, a simultaneous pop frees the slot the new entry lands in.
    assign accept    = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    // Storage has no reset. Entries are only observable through count/out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n && accept) begin
            mem[wr_ptr_reg] <= {ts_reg, state};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ts_reg       <= '0;
            spike_d_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            // Edge history tracks spike every cycle, even while en is low.
            spike_d_reg <= spike;

            if (en) begin
                ts_reg <= ts_reg + TS_W'(1);
            end

            // DEPTH is a power of two, so pointer wrap is the natural rollover.
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end

            if (accept && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !accept) begin
                count_reg <= count_reg - CW'(1);
            end

            // A drop in the same cycle as clr wins: the clear is applied
            // first, and then this drop is recorded.
            if (drop) begin
                overflow_reg <= 1'b1;
                if (clr) begin
                    drop_cnt_reg <= 8'd1;
                end else if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
            end else if (clr) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= '0;
            end
        end
    end

    assign out_valid = (count_reg != '0);
    assign out_data  = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign timestamp = ts_reg;

endmodule

// File: tb/tb_spike_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_spike_event_fifo
//
// Self-checking bench for spike_event_fifo using DEPTH=8 and TS_W=8.
//
// A queue-based reference model predicts the design's behaviour:
//   - an event is a 0 -> 1 transition of spike;
//   - a push writes {timestamp, state} into the queue;
//   - a push into a full queue is dropped, unless a pop happens in the same cycle;
//   - the timestamp counts modulo 256.
//
// Inputs are driven on the falling edge. DUT outputs are compared on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_spike_event_fifo;

    localparam int DEPTH = 8;
    localparam int TS_W  = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   spike;
    logic [7:0]             state;
    logic                   clr;
    logic                   out_ready;
    logic                   out_valid;
    logic [TS_W+7:0]        out_data;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [7:0]             drop_cnt;
    logic [TS_W-1:0]        timestamp;

    spike_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spike     (spike),
        .state     (state),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .timestamp (timestamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_q[$];
    int          m_ts;
    bit          m_prev;
    bit          m_ovf;
    int          m_drop;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s,
                              input logic [7:0] st, input bit c, input bit rd);
        bit          ev;
        bit          do_pop;
        logic [15:0] word;
        if (r) begin
            m_q.delete();
            m_ts   = 0;
            m_prev = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            ev     = s && !m_prev;
            m_prev = s;
            do_pop = (m_q.size() != 0) && rd;
            word   = {m_ts[7:0], st};
            if (do_pop) begin
                $display("pop data=%h", m_q[0]);
                void'(m_q.pop_front());
            end
            if (c) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (ev && e) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(word);
                end else begin
                    m_ovf  = 1;
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end
            end
            if (e) m_ts = (m_ts + 1) % 256;
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
        chk("timestamp", 32'(timestamp), 32'(m_ts));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock cycle: drive the inputs, advance the model, then compare.
    task automatic cyc(input bit r, input bit e, input bit s,
                       input logic [7:0] st, input bit c, input bit rd);
        rst_n     = r;
        en        = e;
        spike     = s;
        state     = st;
        clr       = c;
        out_ready = rd;
        model_step(r, e, s, st, c, rd);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; spike = 1'b0; state = 8'h00; clr = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 8'h00, 0, 0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ts", 32'(timestamp), 32'd0);

        // Two single-cycle spike pulses, captured at timestamps 3 and 10
        for (int k = 0; k < 13; k++)
            cyc(0, 1, (k == 3 || k == 10), (k == 3) ? 8'h80 : 8'h95, 0, 0);
        chk("two_ev_count", 32'(count), 32'd2);
        chk("two_ev_head", 32'(out_data), 32'h0380);
        cyc(0, 1, 0, 8'h00, 0, 1);
        chk("two_ev_second", 32'(out_data), 32'h0A95);

        // Spike held high for 20 cycles yields a single event
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 20; k++) cyc(0, 1, 1, 8'(k), 0, 0);
        chk("held_count", 32'(count), 32'd1);

        // Eleven spike edges into a DEPTH=8 FIFO: three are dropped
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 22; k++) cyc(0, 1, k[0] == 1'b0, 8'(8'h40 + k), 0, 0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_cnt), 32'd3);
        cyc(0, 1, 0, 8'h00, 1, 0);
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_drops", 32'(drop_cnt), 32'd0);
        chk("clr_count", 32'(count), 32'd8);

        // Push and pop together while full: no drop, new entry goes to the tail
        cyc(0, 1, 1, 8'hEE, 0, 1);
        chk("full_pp_count", 32'(count), 32'd8);
        chk("full_pp_drops", 32'(drop_cnt), 32'd0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 8'h00, 0, 1);
        chk("drained", 32'(out_valid), 32'd0);

        // 260 enabled cycles wrap the timestamp; en=0 then blocks pushes
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 260; k++) cyc(0, 1, 0, 8'h00, 0, 0);
        chk("wrap_ts", 32'(timestamp), 32'd4);
        for (int k = 0; k < 10; k++) cyc(0, 0, k[0] == 1'b0, 8'h11, 0, 0);
        chk("en0_count", 32'(count), 32'd0);
        chk("en0_ts", 32'(timestamp), 32'd4);

        // Reset mid-operation with spike held high
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 10; k++) cyc(0, 1, k[0] == 1'b0, 8'h22, 0, 0);
        chk("five_count", 32'(count), 32'd5);
        cyc(1, 1, 1, 8'h33, 0, 1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_drops", 32'(drop_cnt), 32'd0);
        cyc(0, 1, 1, 8'h44, 0, 0);
        chk("post_rst_event", 32'(count), 32'd1);

        // Randomized traffic with occasional reset and clr
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 499) == 0),
                ($urandom_range(0, 9) != 0),
                $urandom_range(0, 1) == 1,
                8'($urandom),
                ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
